fht_stage_sequencer: RTL
========================

// Module: fht_stage_sequencer
// PURPOSE
//  Parametrised control/address sequencer for the 4-bank in-place radix-2 FHT core; runs LOG_N stages.
//  Generates bank read/partner/write addresses, sector/subsector flags, coefficient ROM addresses,
//  ping-pong bank write enables and data/control source selects.
//  Sits between the host start/ready handshake and the bank mixers, butterfly and coef ROM.
// PARAMETERS
//  LOG_N  10  log2 of transform length N; bank depth BANK_LEN = 2^A_BIT, A_BIT = LOG_N-2 (localparam)
//  S_BIT   4  stage counter width, >= clog2(LOG_N)
//  LAT     6  butterfly pipeline latency in cycles (read-to-write delay), >= 1
// PORTS
//  iCLK              in   1      clock
//  iRESET            in   1      asynchronous reset, active-low
//  iSTART            in   1      start pulse, sampled only while oRDY=1
//  oRDY              out  1      idle/ready
//  oDONE             out  1      one-cycle pulse at end of last stage
//  oSTAGE            out  S_BIT  current stage s, 0..LOG_N-1
//  oST_ZERO/oST_LAST out  1      s==0 & !oRDY / s==LOG_N-1 & !oRDY
//  oSECTOR           out  A_BIT  sector index of current read address
//  o2ND_PART_SUBSEC  out  1      read address in 2nd half of its sector
//  oADDR_RD_0/1      out  A_BIT  direct / butterfly-partner read address
//  oADDR_WR_0/1      out  A_BIT  direct / partner write address
//  oADDR_COEF        out  A_BIT  coefficient ROM address
//  oWE_A/oWE_B       out  1      write enable bank set A / B
//  oSOURCE_DATA      out  1      bank-set read select (= s[0])
//  oSOURCE_CONT      out  1      host owns banks (oRDY delayed 1 cycle)
// BEHAVIOUR
//  Reset: oRDY=1, oSOURCE_CONT=1, every other output and internal counter 0.
//  Handshake: iSTART & oRDY -> next cycle oRDY=0, s=0, t=0. iSTART while busy is ignored (incl. last cycle).
//  Stage timer t: 0..STAGE_LEN-1, STAGE_LEN = BANK_LEN+LAT; at t=STAGE_LEN-1, s increments and t wraps to 0.
//  Read counter a = t for t<BANK_LEN; a holds 0 during drain (t>=BANK_LEN) and while idle.
//  Sector size D(s): BANK_LEN for s=0 and 1; BANK_LEN>>(s-1) for s>=2, floored at 1. H = D/2.
//  oSECTOR = a/D; o2ND_PART_SUBSEC = (a mod D) >= H (0 when D=1).
//  oADDR_RD_0 = a; oADDR_RD_1 = a XOR H (= a when D=1).
//  oADDR_COEF = (a << s) truncated to A_BIT bits for 1<=s<A_BIT; 0 for s=0 and s>=A_BIT.
//  Write addresses = read addresses delayed LAT cycles (shift register, no reset-gap bubble).
//  WE: active for LAT<=t<LAT+BANK_LEN; s even -> oWE_B, s odd -> oWE_A; never both; 0 when idle.
//  End: t=STAGE_LEN-1 & s=LOG_N-1 -> next cycle oRDY=1, oDONE=1 for exactly 1 cycle, s=0.
//  Async reset mid-run: immediate return to reset values; no partial-stage completion.
//  All counters mod-width; no arithmetic overflow beyond declared widths.
// CONFIGURATION
//  FHT_SEQ_BITREV_EN defined: on last stage oADDR_WR_0/1 = bit-reversed (A_BIT bits) delayed read
//  addresses, giving natural-order output. Undefined: last-stage writes use direct order like all stages.
// TESTING (LOG_N=4, LAT=2: BANK_LEN=4, STAGE_LEN=6, 4 stages)
//  Reset then idle 5 cycles -> oRDY=1, oSOURCE_CONT=1, WE=0, oDONE=0.
//  iSTART pulse -> oRDY=0 next cycle; oDONE pulses exactly 24 cycles later; oSTAGE steps 0,1,2,3 every 6.
//  s=1, a=0..3 -> RD_1=2,3,0,1; 2ND_PART=0,0,1,1; COEF=0,2,0,2; oWE_A high t=2..5, WR_0=0..3.
//  s=2, a=3 -> oSECTOR=1, RD_1=2, COEF=0; oWE_B at t=2..5; oSOURCE_DATA=0.
//  s=3 with FHT_SEQ_BITREV_EN, t=2..5 -> WR_0=0,2,1,3; without -> 0,1,2,3.
//  iSTART during busy, and iRESET low at s=2,t=3 -> start ignored; reset yields oRDY=1, all outputs 0.

Source files
------------

// File: rtl/fht_stage_sequencer.sv
// ============================================================================
// fht_stage_sequencer
//
// Control and address sequencer for a 4-bank, in-place, radix-2 FHT core.
// Runs LOG_N butterfly stages back to back. Each stage is BANK_LEN read
// cycles followed by LAT drain cycles, so the butterfly pipeline can empty
// before the next stage begins. Writes trail reads by exactly LAT cycles.
// Even stages write bank set B and odd stages write bank set A, so the two
// sets ping-pong.
//
// Optional build macro:
//   FHT_SEQ_BITREV_EN  On the last stage, the write addresses are the
//                      bit-reversed (A_BIT bits) delayed read addresses,
//                      so the result lands in natural order. When the macro
//                      is undefined, every stage writes in direct order.
//
// Parameters:
//   LOG_N  log2 of the transform length (bank depth = 2^(LOG_N-2))
//   S_BIT  stage counter width, >= clog2(LOG_N)
//   LAT    butterfly read-to-write latency in cycles, >= 1
//
// Ports:
//   iCLK, iRESET        clock; asynchronous active-low reset
//   iSTART              start pulse, accepted only while oRDY = 1
//   oRDY / oDONE        idle flag / one-cycle end-of-transform pulse
//   oSTAGE              current stage
//   oST_ZERO, oST_LAST  first / last stage while busy
//   oSECTOR             sector index of the current read address
//   o2ND_PART_SUBSEC    read address lies in the upper half of its sector
//   oADDR_RD_0/1        direct / butterfly-partner read address
//   oADDR_WR_0/1        direct / partner write address (reads delayed LAT)
//   oADDR_COEF          coefficient ROM address
//   oWE_A / oWE_B       write enable for bank set A / B
//   oSOURCE_DATA        bank-set read select (stage LSB)
//   oSOURCE_CONT        host owns the banks (oRDY delayed one cycle)
// ============================================================================
module fht_stage_sequencer #(
    parameter int LOG_N = 10,
    parameter int S_BIT = 4,
    parameter int LAT   = 6
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iSTART,
    output logic             oRDY,
    output logic             oDONE,
    output logic [S_BIT-1:0] oSTAGE,
    output logic             oST_ZERO,
    output logic             oST_LAST,
    output logic [LOG_N-3:0] oSECTOR,
    output logic             o2ND_PART_SUBSEC,
    output logic [LOG_N-3:0] oADDR_RD_0,
    output logic [LOG_N-3:0] oADDR_RD_1,
    output logic [LOG_N-3:0] oADDR_WR_0,
    output logic [LOG_N-3:0] oADDR_WR_1,
    output logic [LOG_N-3:0] oADDR_COEF,
    output logic             oWE_A,
    output logic             oWE_B,
    output logic             oSOURCE_DATA,
    output logic             oSOURCE_CONT
);

    localparam int A_BIT     = LOG_N - 2;
    localparam int BANK_LEN  = 1 << A_BIT;
    localparam int STAGE_LEN = BANK_LEN + LAT;
    localparam int T_BIT     = $clog2(STAGE_LEN);

    localparam logic [T_BIT-1:0] T_LAST  = T_BIT'(STAGE_LEN - 1);
    localparam logic [T_BIT-1:0] T_BANK  = T_BIT'(BANK_LEN);
    localparam logic [T_BIT-1:0] T_WE_LO = T_BIT'(LAT);
    localparam logic [S_BIT-1:0] S_LAST  = S_BIT'(LOG_N - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [S_BIT-1:0] s_reg, s_next;
    logic [T_BIT-1:0] t_reg, t_next;
    logic             done_reg, done_next;
    logic             cont_reg;

    logic             running;
    logic [A_BIT-1:0] a_cur;
    logic [A_BIT-1:0] half;
    logic [A_BIT-1:0] sector;
    logic [A_BIT-1:0] rd1_cur;
    logic [A_BIT-1:0] coef;
    logic             sec2;
    logic             we;
    int               sh;
    int               log2d;

    // Read-to-write alignment lines; index LAT-1 is the oldest entry.
    logic [A_BIT-1:0] rd0_pipe_reg [LAT];
    logic [A_BIT-1:0] rd1_pipe_reg [LAT];
    logic [A_BIT-1:0] wr0_dly;
    logic [A_BIT-1:0] wr1_dly;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_reg <= ST_IDLE;
            s_reg     <= '0;
            t_reg     <= '0;
            done_reg  <= 1'b0;
            cont_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            t_reg     <= t_next;
            done_reg  <= done_next;
            cont_reg  <= (state_reg == ST_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. The stage and timer both return to zero when idle,
    // so every address output naturally reads zero outside a run.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        t_next     = t_reg;
        done_next  = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (iSTART) begin
                    state_next = ST_RUN;
                    s_next     = '0;
                    t_next     = '0;
                end
            end
            ST_RUN: begin
                if (t_reg == T_LAST) begin
                    t_next = '0;
                    if (s_reg == S_LAST) begin
                        state_next = ST_IDLE;
                        s_next     = '0;
                        done_next  = 1'b1;
                    end else begin
                        s_next = s_reg + S_BIT'(1);
                    end
                end else begin
                    t_next = t_reg + T_BIT'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign running = (state_reg == ST_RUN);

    // Read counter follows the timer during the read window and parks at 0
    // during the drain window.
    assign a_cur = (running && (t_reg < T_BANK)) ? t_reg[A_BIT-1:0] : '0;

    // ------------------------------------------------------------------
    // Sector geometry. Sector size D = 2^log2d shrinks by one bit per
    // stage from stage 2 onward and bottoms out at 1. The partner address
    // flips the top bit inside the sector (H = D/2).
    // ------------------------------------------------------------------
    always_comb begin
        sh      = 0;
        log2d   = A_BIT;
        half    = '0;
        sector  = '0;
        sec2    = 1'b0;
        rd1_cur = '0;
        coef    = '0;

        if (s_reg > S_BIT'(1)) begin
            sh = int'(s_reg) - 1;
        end
        log2d = (sh >= A_BIT) ? 0 : (A_BIT - sh);
        if (log2d > 0) begin
            half = A_BIT'(1) << (log2d - 1);
        end
        sector = a_cur >> log2d;
        sec2   = ((a_cur & half) != '0);
        if (running) begin
            rd1_cur = a_cur ^ half;
        end
        // Twiddle index steps by 2^s; only stages 1..A_BIT-1 use the ROM.
        if ((s_reg >= S_BIT'(1)) && (int'(s_reg) < A_BIT)) begin
            coef = a_cur << s_reg;
        end
    end

    // ------------------------------------------------------------------
    // Write address delay lines. They shift every cycle, idle included,
    // so a fresh run never sees a bubble at the stage boundary.
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            rd0_pipe_reg[0] <= '0;
            rd1_pipe_reg[0] <= '0;
        end else begin
            rd0_pipe_reg[0] <= a_cur;
            rd1_pipe_reg[0] <= rd1_cur;
        end
    end

    generate
        for (genvar gi = 1; gi < LAT; gi++) begin : g_pipe
            always_ff @(posedge iCLK or negedge iRESET) begin
                if (!iRESET) begin
                    rd0_pipe_reg[gi] <= '0;
                    rd1_pipe_reg[gi] <= '0;
                end else begin
                    rd0_pipe_reg[gi] <= rd0_pipe_reg[gi-1];
                    rd1_pipe_reg[gi] <= rd1_pipe_reg[gi-1];
                end
            end
        end
    endgenerate

    assign wr0_dly = rd0_pipe_reg[LAT-1];
    assign wr1_dly = rd1_pipe_reg[LAT-1];

`ifdef FHT_SEQ_BITREV_EN
    logic [A_BIT-1:0] wr0_rev;
    logic [A_BIT-1:0] wr1_rev;

    generate
        for (genvar gi = 0; gi < A_BIT; gi++) begin : g_bitrev
            assign wr0_rev[gi] = wr0_dly[A_BIT-1-gi];
            assign wr1_rev[gi] = wr1_dly[A_BIT-1-gi];
        end
    endgenerate

    assign oADDR_WR_0 = oST_LAST ? wr0_rev : wr0_dly;
    assign oADDR_WR_1 = oST_LAST ? wr1_rev : wr1_dly;
`else
    assign oADDR_WR_0 = wr0_dly;
    assign oADDR_WR_1 = wr1_dly;
`endif

    // The write window is the read window shifted by LAT cycles, which is
    // exactly the tail of the stage (timer LAT..STAGE_LEN-1).
    assign we = running && (t_reg >= T_WE_LO);

    assign oRDY             = !running;
    assign oDONE            = done_reg;
    assign oSTAGE           = s_reg;
    assign oST_ZERO         = running && (s_reg == '0);
    assign oST_LAST         = running && (s_reg == S_LAST);
    assign oSECTOR          = sector;
    assign o2ND_PART_SUBSEC = sec2;
    assign oADDR_RD_0       = a_cur;
    assign oADDR_RD_1       = rd1_cur;
    assign oADDR_COEF       = coef;
    assign oWE_A            = we && s_reg[0];
    assign oWE_B            = we && !s_reg[0];
    assign oSOURCE_DATA     = s_reg[0];
    assign oSOURCE_CONT     = cont_reg;

endmodule
